// File: rtl/tx_header_insert.sv
// rtl/tx_header_insert.sv - Ethernet/IPv4/UDP header builder and 42-byte payload realigner
module tx_header_insert #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int IP_TTL     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  meta_valid,
  output logic                  meta_ready,
  input  logic [47:0]           meta_mac_dst,
  input  logic [47:0]           meta_mac_src,
  input  logic [31:0]           meta_ip_src,
  input  logic [31:0]           meta_ip_dst,
  input  logic [15:0]           meta_l4_src,
  input  logic [15:0]           meta_l4_dst,
  input  logic [15:0]           meta_payload_len,
  input  logic [15:0]           meta_tuser_src,
  input  logic [15:0]           meta_tuser_dst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tuser_size,
  output logic [15:0]           m_axis_tuser_src,
  output logic [15:0]           m_axis_tuser_dst
);

  localparam int HDR_BYTES = 42;
  localparam int HDR_BITS  = HDR_BYTES * 8;
  localparam int LOW_BYTES = KEEP_WIDTH - HDR_BYTES;
  localparam int LOW_BITS  = DATA_WIDTH - HDR_BITS;
  localparam logic [7:0] TTL_B = 8'(IP_TTL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_FIRST,
    S_BODY,
    S_FLUSH
  } state_t;

  state_t state;

  logic [47:0] mac_dst_r;
  logic [47:0] mac_src_r;
  logic [31:0] ip_src_r;
  logic [31:0] ip_dst_r;
  logic [15:0] l4_src_r;
  logic [15:0] l4_dst_r;
  logic [15:0] len_r;
  logic [15:0] tuser_src_r;
  logic [15:0] tuser_dst_r;
  logic [15:0] ip_id_cnt;
  logic [15:0] ip_id_r;
  logic [15:0] csum_r;
  logic [15:0] size_r;

  logic [HDR_BITS-1:0]  carry_data;
  logic [HDR_BYTES-1:0] carry_keep;

  logic [15:0]         total_len;
  logic [15:0]         udp_len;
  logic [31:0]         csum_sum;
  logic [31:0]         csum_f1;
  logic [15:0]         csum_calc;
  logic [HDR_BITS-1:0] hdr;

  logic                  out_free;
  logic                  s_fire;
  logic [HDR_BITS-1:0]   front;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_WIDTH-1:0] beat_keep;
  logic                  beat_short;

  logic                  ld_en;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [KEEP_WIDTH-1:0] ld_keep;
  logic                  ld_last;
  state_t                ld_state;

  assign total_len = len_r + 16'd28;
  assign udp_len   = len_r + 16'd8;

  // Checksum word itself is left out of the sum; nine words cannot carry past 20 bits.
  assign csum_sum = 32'h0000_4500 + {16'h0, total_len} + {16'h0, ip_id_r} + 32'h0000_4000
                  + {16'h0, TTL_B, 8'h11}
                  + {16'h0, ip_src_r[31:16]} + {16'h0, ip_src_r[15:0]}
                  + {16'h0, ip_dst_r[31:16]} + {16'h0, ip_dst_r[15:0]};
  assign csum_f1   = {16'h0, csum_sum[15:0]} + {16'h0, csum_sum[31:16]};
  assign csum_calc = ~(csum_f1[15:0] + csum_f1[31:16]);

  assign hdr = {mac_dst_r, mac_src_r, 16'h0800,
                8'h45, 8'h00, total_len, ip_id_r, 16'h4000,
                TTL_B, 8'h11, csum_r, ip_src_r, ip_dst_r,
                l4_src_r, l4_dst_r, udp_len, 16'h0000};

  assign meta_ready    = rst_n && (state == S_IDLE);
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = rst_n && out_free &&
                         (((state == S_FIRST) && (len_r != 16'd0)) || (state == S_BODY));
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  // Each input beat splits: its first 22 bytes complete the current output beat,
  // the remaining 42 bytes wait in carry for the next one.
  assign front      = (state == S_FIRST) ? hdr : carry_data;
  assign beat_data  = {front, s_axis_tdata[DATA_WIDTH-1 -: LOW_BITS]};
  assign beat_keep  = {{HDR_BYTES{1'b1}}, s_axis_tkeep[KEEP_WIDTH-1 -: LOW_BYTES]};
  assign beat_short = !s_axis_tkeep[KEEP_WIDTH-1-LOW_BYTES];

  always_comb begin
    ld_en    = 1'b0;
    ld_data  = '0;
    ld_keep  = '0;
    ld_last  = 1'b0;
    ld_state = state;
    case (state)
      S_FIRST, S_BODY: begin
        if ((state == S_FIRST) && (len_r == 16'd0)) begin
          if (out_free) begin
            ld_en    = 1'b1;
            ld_data  = {hdr, {LOW_BITS{1'b0}}};
            ld_keep  = {{HDR_BYTES{1'b1}}, {LOW_BYTES{1'b0}}};
            ld_last  = 1'b1;
            ld_state = S_IDLE;
          end
        end else if (s_fire) begin
          ld_en   = 1'b1;
          ld_data = beat_data;
          ld_keep = beat_keep;
          ld_last = s_axis_tlast && beat_short;
          if (!s_axis_tlast)
            ld_state = S_BODY;
          else if (beat_short)
            ld_state = S_IDLE;
          else
            ld_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          ld_en    = 1'b1;
          ld_data  = {carry_data, {LOW_BITS{1'b0}}};
          ld_keep  = {carry_keep, {LOW_BYTES{1'b0}}};
          ld_last  = 1'b1;
          ld_state = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      mac_dst_r         <= '0;
      mac_src_r         <= '0;
      ip_src_r          <= '0;
      ip_dst_r          <= '0;
      l4_src_r          <= '0;
      l4_dst_r          <= '0;
      len_r             <= '0;
      tuser_src_r       <= '0;
      tuser_dst_r       <= '0;
      ip_id_cnt         <= '0;
      ip_id_r           <= '0;
      csum_r            <= '0;
      size_r            <= '0;
      carry_data        <= '0;
      carry_keep        <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser_size <= '0;
      m_axis_tuser_src  <= '0;
      m_axis_tuser_dst  <= '0;
    end else begin
      if (ld_en) begin
        m_axis_tvalid     <= 1'b1;
        m_axis_tdata      <= ld_data;
        m_axis_tkeep      <= ld_keep;
        m_axis_tlast      <= ld_last;
        m_axis_tuser_size <= size_r;
        m_axis_tuser_src  <= tuser_src_r;
        m_axis_tuser_dst  <= tuser_dst_r;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (s_fire) begin
        carry_data <= s_axis_tdata[HDR_BITS-1:0];
        carry_keep <= s_axis_tkeep[HDR_BYTES-1:0];
      end

      case (state)
        S_IDLE: begin
          if (meta_valid) begin
            mac_dst_r   <= meta_mac_dst;
            mac_src_r   <= meta_mac_src;
            ip_src_r    <= meta_ip_src;
            ip_dst_r    <= meta_ip_dst;
            l4_src_r    <= meta_l4_src;
            l4_dst_r    <= meta_l4_dst;
            len_r       <= meta_payload_len;
            tuser_src_r <= meta_tuser_src;
            tuser_dst_r <= meta_tuser_dst;
            ip_id_r     <= ip_id_cnt;
            ip_id_cnt   <= ip_id_cnt + 16'd1;
            state       <= S_CSUM;
          end
        end
        S_CSUM: begin
          csum_r <= csum_calc;
          size_r <= len_r + 16'd42;
          state  <= S_FIRST;
        end
        default: state <= ld_state;
      endcase
    end
  end

endmodule

// File: doc/tx_header_insert.md
Name: tx_header_insert

Overview:
- TX-side counterpart of the RX header parser. Takes per-packet metadata and a raw UDP payload stream, then emits a complete Ethernet/IPv4/UDP frame on a 512-bit AXI-Stream.
- Builds the 42-byte header, computes the IPv4 header checksum, and prepends the header by realigning the payload by 42 bytes across beats.
- Sits in box_250mhz ahead of the TX packet path.

Parameters:
- DATA_WIDTH, 512, stream data width in bits; only 512 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- IP_TTL, 64, TTL written into every IPv4 header.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- meta_valid  input  1  metadata valid.
- meta_ready  output  1  metadata accepted; equals (state==IDLE).
- meta_mac_dst  input  48  destination MAC.
- meta_mac_src  input  48  source MAC.
- meta_ip_src  input  32  IPv4 source address.
- meta_ip_dst  input  32  IPv4 destination address.
- meta_l4_src  input  16  UDP source port.
- meta_l4_dst  input  16  UDP destination port.
- meta_payload_len  input  16  UDP payload bytes; must equal the byte count of the payload stream.
- meta_tuser_src  input  16  copied to m_axis_tuser_src.
- meta_tuser_dst  input  16  copied to m_axis_tuser_dst.
- s_axis_tvalid / s_axis_tready  input / output  1 / 1  payload handshake.
- s_axis_tdata  input  DATA_WIDTH  payload data.
- s_axis_tkeep  input  KEEP_WIDTH  payload byte enables.
- s_axis_tlast  input  1  last payload beat.
- m_axis_tvalid / m_axis_tready  output / input  1 / 1  frame handshake.
- m_axis_tdata  output  DATA_WIDTH  frame data.
- m_axis_tkeep  output  KEEP_WIDTH  frame byte enables.
- m_axis_tlast  output  1  last frame beat.
- m_axis_tuser_size  output  16  frame size in bytes = 42 + payload_len, mod 2^16.
- m_axis_tuser_src  output  16  copy of meta_tuser_src.
- m_axis_tuser_dst  output  16  copy of meta_tuser_dst.

Behaviour:
- Byte order: byte i sits at tdata[DATA_WIDTH-1-8i -: 8], and tkeep[KEEP_WIDTH-1-i] enables byte i. Keep is contiguous from the MSB. Payload keep is full on every beat except the tlast beat.
- Header bytes:
  - 0-5 MAC dst; 6-11 MAC src; 12-13 0x0800.
  - 14 0x45; 15 0x00; 16-17 total_len = 28 + len; 18-19 ip_id; 20-21 0x4000 (DF).
  - 22 IP_TTL; 23 0x11; 24-25 checksum; 26-29 IP src; 30-33 IP dst.
  - 34-35 UDP src; 36-37 UDP dst; 38-39 UDP len = 8 + len; 40-41 0x0000 (no UDP checksum).
  - All length sums are 16-bit, mod 2^16.
- Checksum: ones-complement sum of the 9 IPv4 header 16-bit words (checksum word excluded). Fold carries twice, invert. Computed in CSUM and registered.
- ip_id: 16-bit counter, reset 0. The value used is the one current at meta accept; it increments after each accept and wraps 0xFFFF to 0x0000.
- Output register: m_axis_* held stable while tvalid && !tready. A new beat loads only when !m_axis_tvalid || m_axis_tready. s_axis_tready = (state in FIRST/BODY) && payload needed && (!m_axis_tvalid || m_axis_tready).
- States:
  - IDLE: meta_ready=1. On meta_valid, latch all metadata, go to CSUM.
  - CSUM: one cycle. Register checksum and tuser fields, go to FIRST.
  - FIRST:
    - If len==0: emit one beat (header only, 42 bytes keep, tlast) without touching the payload, go to IDLE.
    - Otherwise, on payload accept: out = header42 + payload bytes 0-21. Carry = payload bytes 22-63.
    - tlast with ≤22 valid bytes: out.tlast, go to IDLE. tlast with >22 bytes: go to FLUSH. No tlast: go to BODY.
  - BODY: on accept, out = carry42 + new bytes 0-21. Same tlast rules as FIRST.
  - FLUSH: emit carry (valid bytes − 22), tlast, go to IDLE.
- Latency: meta accept at cycle N; the first payload beat can be accepted at N+2. Each output beat is valid the cycle after its source payload beat is accepted (header-only beat: valid at N+3).
- Metadata arriving mid-packet is not accepted until IDLE.
- Reset, including mid-packet: state to IDLE; m_axis_tvalid, tlast, s_axis_tready, meta_ready (until the next cycle) all 0; tdata, tkeep, tuser outputs 0; ip_id 0. The partial frame is dropped without tlast, and the remaining upstream payload is the source's responsibility.

Test Plan:
- First packet after reset: MAC dst 02:00:00:00:00:02, MAC src 02:00:00:00:00:01, IP 10.0.0.1 → 10.0.0.2, ports 1234→80, len 18, one tlast beat. Required: one out beat with 60 keep bytes, tlast, bytes 16-17 = 0x002E, 18-19 = 0x0000, 24-25 = 0x26BD, 38-39 = 0x001A, tuser_size 60.
- len 0 → one beat with 42 keep bytes, tlast, total_len 0x001C, UDP len 0x0008, s_axis_tready never high.
- len 64, single full beat tlast → beat 1 full keep (header + bytes 0-21), beat 2 holds bytes 22-63 with 42 keep bytes and tlast; tuser_size 106.
- len 100 (64 + 36) → 3 beats of 64, 64, 14 bytes; payload byte k appears at frame byte 42+k.
- Random m_axis_tready (~50%) with back-to-back packets → output data identical to the no-stall case, no beat lost or duplicated, ip_id 0, 1, 2…; after 65536 packets ip_id wraps to 0.
- Assert rst_n low for one cycle during BODY → next cycle m_axis_tvalid=0, meta_ready=1, and the next packet is correct with ip_id 0.
